triangle_dispatch_scheduler: RTL

- Drains the Triangle FIFO (224-bit triangle setup words) and dispatches each word to one of NUM_UNITS scanline (CalcLine) units.
- Arbitration between ready units is round-robin.
- Counts triangles dispatched per frame.
- Raises a one-cycle frameDone once PreCalc has finished, the FIFO is empty and all units are idle.
- Sits between the Triangle FIFO read port and the CalcLine unit array.

---
 rtl/triangle_dispatch_scheduler_if.sv | 24 ++
 rtl/triangle_dispatch_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/triangle_dispatch_scheduler_if.sv
// Handshake bundle between the scheduler, the Triangle FIFO read port and the CalcLine unit array.
// master = scheduler side, slave = FIFO/unit side.
interface triangle_dispatch_scheduler_if #(
   parameter int NUM_UNITS = 2,
   parameter int DATA_W    = 224
);
   logic [DATA_W-1:0]    TriangleFIFO_ReadData;
   logic                 TriangleFIFO_empty;
   logic                 TriangleFIFO_pop;
   logic [NUM_UNITS-1:0] Unit_ready;
   logic [NUM_UNITS-1:0] Unit_busy;
   logic [NUM_UNITS-1:0] Unit_valid;
   logic [DATA_W-1:0]    Unit_data;

   modport master (
      input  TriangleFIFO_ReadData, TriangleFIFO_empty, Unit_ready, Unit_busy,
      output TriangleFIFO_pop, Unit_valid, Unit_data
   );

   modport slave (
      output TriangleFIFO_ReadData, TriangleFIFO_empty, Unit_ready, Unit_busy,
      input  TriangleFIFO_pop, Unit_valid, Unit_data
   );
endinterface

// File: rtl/triangle_dispatch_scheduler.sv
// Pops triangle setup words from the Triangle FIFO and hands each one to a ready CalcLine unit,
// round-robin, counting triangles per frame and flagging the end of the frame.
module triangle_dispatch_scheduler #(
   parameter int NUM_UNITS = 2,
   parameter int DATA_W    = 224,
   parameter int CNT_W     = 16
) (
   input  logic                           clk100,
   input  logic                           rst,
   input  logic                           nextFrame,
   input  logic                           PreCalc_done,
   triangle_dispatch_scheduler_if.master  bus,
   output logic                           frameDone,
   output logic [CNT_W-1:0]               triCount
);

   localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, OFFER, DONE} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_q, rr_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pop_q, pop_d;
   logic                 frame_done_q, frame_done_d;

   logic [PTR_W-1:0]     grant;
   logic                 grant_found;
   int                   scan_off;
   int                   best_off;
   logic [NUM_UNITS-1:0] unit_valid;
   logic                 transfer;

   // Winner is the ready unit with the smallest rotational distance from rr_q.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      scan_off    = 0;
      best_off    = NUM_UNITS;
      for (int j = 0; j < NUM_UNITS; j++) begin
         scan_off = (j + NUM_UNITS - int'(rr_q)) % NUM_UNITS;
         if (bus.Unit_ready[j] && (scan_off < best_off)) begin
            best_off    = scan_off;
            grant       = PTR_W'(j);
            grant_found = 1'b1;
         end
      end
   end

   // The offer is withdrawn during nextFrame so a discarded word can never be accepted.
   always_comb begin
      unit_valid = '0;
      for (int j = 0; j < NUM_UNITS; j++) begin
         unit_valid[j] = (state_q == OFFER) && !nextFrame && grant_found && (grant == PTR_W'(j));
      end
   end

   assign transfer = |(unit_valid & bus.Unit_ready);

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      pop_d        = 1'b0;
      frame_done_d = 1'b0;
      if (nextFrame) begin
         state_d = IDLE;
         rr_d    = '0;
         data_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.TriangleFIFO_empty) begin
                  pop_d   = 1'b1;
                  state_d = FETCH;
               end else if (PreCalc_done && (bus.Unit_busy == '0)) begin
                  frame_done_d = 1'b1;
                  state_d      = DONE;
               end
            end
            FETCH: begin
               data_d  = bus.TriangleFIFO_ReadData;
               state_d = OFFER;
            end
            OFFER: begin
               if (transfer) begin
                  rr_d = (grant == PTR_W'(NUM_UNITS - 1)) ? '0 : grant + 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (!bus.TriangleFIFO_empty) begin
                     pop_d   = 1'b1;
                     state_d = FETCH;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         pop_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         pop_q        <= pop_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.TriangleFIFO_pop = pop_q;
   assign bus.Unit_valid       = unit_valid;
   assign bus.Unit_data        = data_q;
   assign frameDone            = frame_done_q;
   assign triCount             = cnt_q;

endmodule
